score_display_ctrl: RTL
=======================

Name: score_display_ctrl

Overview:
Sequences the score digits shown on the HEX displays in the Flappy Bird game. Holds a saturating multi-digit BCD score counter and a high-score register. Outputs one BCD nibble per digit, plus blanking flags, to the downstream per-digit BCD-to-7-segment decoders. After game over it alternates the display between the final score and the high score.

Parameters:
NUM_DIGITS, 3, number of BCD digits in the score, high score and display outputs (1..6)
TOGGLE_CYCLES, 25000000, clock cycles each value is shown while alternating in game-over (0.5 s at 50 MHz); must be >= 2

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state including high score
inc  input  1  score event, level; one point is counted per 0->1 transition
clear  input  1  new game, level; zeroes score and returns to play
game_over  input  1  game-over indication, level; its 0->1 transition ends play
digit_bcd  output  4*NUM_DIGITS  displayed value; nibble [4i+3:4i] is digit i, digit 0 least significant; always 0..9
digit_blank  output  NUM_DIGITS  1 = digit i is a leading zero and must be driven dark
show_high  output  1  1 = digit_bcd currently shows the high score
score  output  4*NUM_DIGITS  current score, BCD, same digit order

Behaviour:
- Edge detect: inc_q and go_q are registered copies of inc and game_over, each cleared by reset.
  - inc_rise = inc & ~inc_q; go_rise = game_over & ~go_q, evaluated combinationally.
  - Action occurs on the same clock edge, so the result is visible one cycle after inc/game_over is first sampled high.
  - A held-high input counts once.
- States: PLAY, OVER_SCORE, OVER_HIGH. Reset state is PLAY.
- Reset values: score=0, high=0, timer=0, show_high=0, digit_bcd=0, digit_blank=all ones except bit 0 (display reads "0").
- Priority each cycle: reset > clear > go_rise > inc_rise.
- clear, from any state: score<=0, timer<=0, state<=PLAY; high is retained.
- PLAY:
  - inc_rise increments score as a BCD ripple: digit 9 wraps to 0 with carry into the next digit.
  - When score is all nines, inc_rise leaves it unchanged (saturate, no wrap to 0).
  - go_rise: state<=OVER_SCORE, timer<=0. If score > high (BCD compare equals binary compare), high<=score on the same edge.
  - go_rise and inc_rise in the same cycle: the increment is dropped; the compare uses the pre-increment score.
- OVER_SCORE / OVER_HIGH:
  - inc and go_rise are ignored.
  - timer counts 0..TOGGLE_CYCLES-1. On the edge where timer==TOGGLE_CYCLES-1, timer<=0 and state toggles OVER_SCORE<->OVER_HIGH.
- Display mux: digit_bcd=high in OVER_HIGH, otherwise score. show_high=1 only in OVER_HIGH.
- Blanking: digit_blank[i]=1 iff the displayed digit i and every more-significant displayed digit are 0, for i>=1. digit_blank[0] is always 0.
- digit_bcd, digit_blank and show_high are combinational from registered state: no glitch paths from inputs, and no added latency beyond the state update.
- No nibble ever leaves 0..9, so the downstream decoders never see an invalid code.
- Reset mid-game or mid-alternation: next cycle all state is at its reset values, including high=0.

Test Plan:
- Reset, then 12 separate inc pulses (1 cycle high, 1 low) -> score=0x012 after the 12th, one cycle after each rising edge; digit_blank=3'b100.
- inc held high 10 cycles from score 0 -> score=0x001 only; drop inc then raise again -> 0x002.
- Score preset to 0x998 via pulses, then 3 inc pulses -> 0x999, 0x999, 0x999 (saturates, no wrap).
- TOGGLE_CYCLES=4, score 0x025, high 0, raise game_over:
  - high=0x025 next cycle; show_high=0 for 4 cycles, then 1 for 4 cycles, repeating.
  - inc pulses during OVER do not change score.
- clear, reach score 0x007, game_over -> high stays 0x025.
  - OVER_HIGH shows digit_bcd=0x025, blank=3'b100; OVER_SCORE shows 0x007, blank=3'b110.
- Same cycle: inc and game_over rise together at score 0x030 with high 0x030 -> score stays 0x030 and high unchanged; reset during OVER_HIGH -> score=0, high=0, state PLAY next cycle.

Source files
------------

// File: rtl/score_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// score_display_ctrl_if
// Bundles the game-side controls and the display-side results of the score
// display controller.
//
// Signals:
//   inc         game -> ctrl  score event (level, counted on 0->1)
//   clear       game -> ctrl  new game (level)
//   game_over   game -> ctrl  game-over indication (level, acted on at 0->1)
//   digit_bcd   ctrl -> disp  displayed value, one BCD nibble per digit
//   digit_blank ctrl -> disp  1 = digit is a leading zero, drive it dark
//   show_high   ctrl -> disp  1 = digit_bcd currently shows the high score
//   score       ctrl -> game  current score, BCD
//
// Modports:
//   master : game/display side (drives controls, observes results)
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface score_display_ctrl_if #(
    parameter int NUM_DIGITS = 3
);
    logic                    inc;
    logic                    clear;
    logic                    game_over;
    logic [4*NUM_DIGITS-1:0] digit_bcd;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic                    show_high;
    logic [4*NUM_DIGITS-1:0] score;

    modport master (
        output inc,
        output clear,
        output game_over,
        input  digit_bcd,
        input  digit_blank,
        input  show_high,
        input  score
    );

    modport slave (
        input  inc,
        input  clear,
        input  game_over,
        output digit_bcd,
        output digit_blank,
        output show_high,
        output score
    );
endinterface

// File: rtl/score_display_ctrl.sv
// -----------------------------------------------------------------------------
// score_display_ctrl
// Keeps a saturating multi-digit BCD score and a high-score register for the
// Flappy Bird game and selects what the HEX displays show. During play the
// score is shown; after game over the display alternates between the final
// score and the high score every TOGGLE_CYCLES clocks.
//
// Parameters:
//   NUM_DIGITS    number of BCD digits (1..6)
//   TOGGLE_CYCLES clocks each value is shown while alternating (>= 2)
//
// Ports:
//   clk    input   system clock, rising edge
//   reset  input   synchronous active-high, clears everything incl. high score
//   bus    slave   controls (inc, clear, game_over) and display results
//                  (digit_bcd, digit_blank, show_high, score)
//
// All display outputs are decoded combinationally from registered state only,
// so no input can glitch them and they follow the state with no extra delay.
// -----------------------------------------------------------------------------
module score_display_ctrl #(
    parameter int NUM_DIGITS    = 3,
    parameter int TOGGLE_CYCLES = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    score_display_ctrl_if.slave   bus
);

    localparam int SW = 4 * NUM_DIGITS;
    localparam int TW = $clog2(TOGGLE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TOGGLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_OVER_SCORE = 2'd1,
        ST_OVER_HIGH  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // Ripple-carry BCD increment: a digit at 9 wraps to 0 and carries on.
    function automatic logic [SW-1:0] f_bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // True when every digit is 9, i.e. the score is at its ceiling.
    function automatic logic f_all_nines(input logic [SW-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                r = 1'b0;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [SW-1:0] r_score;
    logic [SW-1:0] r_high;
    logic [TW-1:0] r_timer;
    logic          r_inc_q;
    logic          r_go_q;

    state_t        w_state_nxt;
    logic [SW-1:0] w_score_nxt;
    logic [SW-1:0] w_high_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_inc_rise;
    logic          w_go_rise;

    logic [SW-1:0]         w_disp;
    logic [NUM_DIGITS-1:0] w_blank;

    assign w_inc_rise = bus.inc & ~r_inc_q;
    assign w_go_rise  = bus.game_over & ~r_go_q;

    // State register: edge-detect copies, FSM state, score, high score, timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_PLAY;
            r_score <= '0;
            r_high  <= '0;
            r_timer <= '0;
            r_inc_q <= 1'b0;
            r_go_q  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_score <= w_score_nxt;
            r_high  <= w_high_nxt;
            r_timer <= w_timer_nxt;
            r_inc_q <= bus.inc;
            r_go_q  <= bus.game_over;
        end
    end

    // Next-state logic; clear beats game-over, which beats a score event.
    always_comb begin
        w_state_nxt = r_state;
        w_score_nxt = r_score;
        w_high_nxt  = r_high;
        w_timer_nxt = r_timer;

        if (bus.clear) begin
            w_state_nxt = ST_PLAY;
            w_score_nxt = '0;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_go_rise) begin
                        // A coincident score event is dropped: the compare
                        // uses the score as it stands.
                        w_state_nxt = ST_OVER_SCORE;
                        w_timer_nxt = '0;
                        // Digit-ordered BCD compares the same as binary.
                        if (r_score > r_high) begin
                            w_high_nxt = r_score;
                        end else begin
                            w_high_nxt = r_high;
                        end
                    end else if (w_inc_rise && !f_all_nines(r_score)) begin
                        w_score_nxt = f_bcd_inc(r_score);
                    end else begin
                        w_score_nxt = r_score;
                    end
                end
                ST_OVER_SCORE, ST_OVER_HIGH: begin
                    if (r_timer == TIMER_LAST) begin
                        w_timer_nxt = '0;
                        w_state_nxt = (r_state == ST_OVER_SCORE) ? ST_OVER_HIGH
                                                                 : ST_OVER_SCORE;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                default: begin
                    // Unused encoding: fall back to a clean play state.
                    w_state_nxt = ST_PLAY;
                    w_score_nxt = '0;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // Display source select and leading-zero blanking from MSB downward.
    always_comb begin
        logic v_all_zero;
        w_disp     = (r_state == ST_OVER_HIGH) ? r_high : r_score;
        w_blank    = '0;
        v_all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_all_zero = v_all_zero & (w_disp[4*i +: 4] == 4'd0);
            w_blank[i] = v_all_zero;
        end
    end

    assign bus.digit_bcd   = w_disp;
    assign bus.digit_blank = w_blank;
    assign bus.show_high   = (r_state == ST_OVER_HIGH);
    assign bus.score       = r_score;

endmodule
